// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down-counting timer.
package down_counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter with a registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTORELOAD_EN to add the auto_reload input and periodic reload mode.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  input  logic             auto_reload,
`endif
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             mode_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= ZERO;
      tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= ZERO;
      mode_q   <= 1'b0;
`endif
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (load_val != ZERO) begin
              cnt_q   <= load_val;
              state_q <= COUNT;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              reload_q <= load_val;
              mode_q   <= auto_reload;
`endif
            end else begin
              // A zero load expires immediately without ever counting.
              cnt_q <= ZERO;
              tc_q  <= 1'b1;
            end
          end
        end
        COUNT: begin
          // Stop outranks expiry so an abort on the final edge never pulses tc.
          if (stop) begin
            state_q <= IDLE;
          end else if (cnt_q == ONE) begin
            tc_q <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            if (mode_q) begin
              cnt_q <= reload_q;
            end else begin
              cnt_q   <= ZERO;
              state_q <= IDLE;
            end
`else
            cnt_q   <= ZERO;
            state_q <= IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q    = cnt_q;
  assign busy = (state_q == COUNT);
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized and directed checks of down_counter_timer against an elapsed-time model.
module tb_down_counter_timer;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;

  int errors = 0;
  int checks = 0;

  // Model: the timer is described by whether it runs, its period N and edges since start.
  bit m_run = 0;
  bit m_ar  = 0;
  int m_n   = 0;
  int m_el  = 0;
  int m_q   = 0;
  bit m_tc  = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    .auto_reload (auto_reload),
`endif
    .load_val    (load_val),
    .q           (q),
    .busy        (busy),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input int lv, input bit ar);
    m_tc = 0;
    if (r) begin
      m_run = 0; m_ar = 0; m_n = 0; m_el = 0; m_q = 0;
    end else if (m_run) begin
      if (p) begin
        m_run = 0;
      end else begin
        m_el++;
        if (m_ar) begin
          m_q  = m_n - (m_el % m_n);
          m_tc = (m_el % m_n) == 0;
        end else begin
          m_q  = m_n - m_el;
          m_tc = (m_el == m_n);
          if (m_el == m_n) m_run = 0;
        end
      end
    end else if (s) begin
      m_n = lv;
      if (lv == 0) begin
        m_q  = 0;
        m_tc = 1;
      end else begin
        m_run = 1;
        m_el  = 0;
        m_q   = lv;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        m_ar  = ar;
`else
        m_ar  = 0;
`endif
      end
    end
  endtask

  task automatic step(input string tag, input bit r, input bit s, input bit p,
                      input int lv, input bit ar);
    @(negedge clk);
    reset = r; start = s; stop = p; load_val = W'(lv); auto_reload = ar;
    @(posedge clk);
    model_edge(r, s, p, lv, ar);
    #1;
    $display("%s r=%0b s=%0b p=%0b lv=%0d ar=%0b -> q=%0d busy=%0b tc=%0b",
             tag, r, s, p, lv, ar, q, busy, tc);
    check({tag, ".q"}, int'(q), m_q % MOD);
    check({tag, ".busy"}, int'(busy), int'(m_run));
    check({tag, ".tc"}, int'(tc), int'(m_tc));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int tc_seen;
    // Reset held two edges.
    step("rst", 1, 0, 0, 0, 0);
    step("rst", 1, 1, 1, 7, 0);
    check("rst_q_const", int'(q), 0);
    idle("post_rst", 2);

    // One-shot N=4: q 4,3,2,1,0 then tc only after the final edge.
    step("one_shot", 0, 1, 0, 4, 0);
    check("one_shot_q0", int'(q), 4);
    idle("one_shot", 4);
    check("one_shot_tc", int'(tc), 1);
    idle("one_shot_after", 2);

    // Stop at q=6 holds the value; a later start restarts cleanly.
    step("stop", 0, 1, 0, 9, 0);
    idle("stop", 3);
    step("stop_hit", 0, 0, 1, 0, 0);
    check("stop_hold", int'(q), 6);
    idle("stop_idle", 3);
    step("restart", 0, 1, 1, 3, 0);
    idle("restart", 4);

    // Zero load pulses tc for one cycle and stays idle.
    step("zero", 0, 1, 0, 0, 0);
    idle("zero", 2);

    // Full-scale load: 15 decrements, tc exactly once.
    tc_seen = 0;
    step("full", 0, 1, 0, 15, 0);
    for (int i = 0; i < 17; i++) begin
      step("full", 0, 1, 0, 2, 0);
      if (tc) tc_seen++;
    end
    check("full_tc_count", tc_seen, 1);

    // Stop coinciding with q==1 suppresses tc; start in COUNT ignored.
    step("stop_last", 0, 1, 0, 2, 0);
    step("stop_last", 0, 1, 0, 9, 0);
    step("stop_last", 0, 0, 1, 0, 0);
    idle("stop_last", 2);

    // Reset mid-count at q=5.
    step("mid_rst", 0, 1, 0, 8, 0);
    idle("mid_rst", 3);
    step("mid_rst", 1, 0, 0, 0, 0);
    idle("mid_rst", 2);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    step("ar3", 0, 1, 0, 3, 1);
    for (int i = 0; i < 10; i++) step("ar3", 0, (i == 4), 0, 7, 0);
    step("ar3_stop", 0, 0, 1, 0, 0);
    idle("ar3", 2);
    step("ar1", 0, 1, 0, 1, 1);
    idle("ar1", 4);
    step("ar1_stop", 0, 0, 1, 0, 0);
    idle("ar1", 2);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0,
           int'($urandom_range(0, MOD - 1)),
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: load load_val and begin counting down.
REQ-005 The block SHALL have port stop, input, 1 bit: abort counting and hold the current value.
REQ-006 The block SHALL have port load_val, input, WIDTH bits: start value N.
REQ-007 The block SHALL have port q, output, WIDTH bits: current count, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in COUNT.
REQ-009 The block SHALL have port tc, output, 1 bit: terminal-count pulse, exactly one cycle, registered.

Function
REQ-010 The FSM SHALL have states IDLE and COUNT only.
REQ-011 In IDLE, start=1 with load_val=N>0 SHALL set q<=N and enter COUNT at that edge; busy SHALL be 1 from the next cycle.
REQ-012 In IDLE, start=1 with load_val=0 SHALL leave the FSM in IDLE with q<=0 and tc<=1 for one cycle.
REQ-013 In COUNT, each edge SHALL set q<=q-1 modulo 2^WIDTH, with no skipped or repeated values.
REQ-014 In COUNT with q==1, the next edge SHALL set q<=0 and tc<=1; in one-shot mode it SHALL return to IDLE, so tc fires N edges after the start edge.
REQ-015 In COUNT, stop=1 SHALL return to IDLE with q held and no tc; when stop and expiry coincide, stop wins and tc stays 0.
REQ-016 In COUNT, start SHALL be ignored; no restart.
REQ-017 In IDLE, stop SHALL be ignored; start=1 together with stop=1 in IDLE SHALL behave as start alone.
REQ-018 In IDLE, q SHALL hold its last value and tc SHALL be 0 except as stated in REQ-012 and REQ-014.
REQ-019 tc SHALL never be high for two consecutive cycles in one-shot mode.

Reset
REQ-020 reset=1 at an edge SHALL force state=IDLE, q=0, busy=0, tc=0, and clear the reload register and the mode flag.
REQ-021 reset SHALL take priority over start, stop and expiry in any state, including mid-count; no tc SHALL be produced by a reset.

Configuration
REQ-022 Macro DOWN_COUNTER_AUTORELOAD_EN SHALL control the auto-reload feature.
REQ-023 With the macro defined, the block SHALL add input port auto_reload, 1 bit; its value is sampled at start together with load_val into an internal reload register.
REQ-024 With the macro defined and auto_reload captured as 1, expiry SHALL set q<=N instead of 0, pulse tc, and remain in COUNT; tc SHALL repeat every N cycles until stop or reset.
REQ-025 With the macro defined, the N=1 auto-reload case SHALL hold tc high continuously with q=1.
REQ-026 Without the macro, the auto_reload port, reload register and mode flag SHALL be absent, and behaviour SHALL be one-shot only.

Structure
REQ-027 Package down_counter_pkg SHALL hold the state type (IDLE, COUNT) and the WIDTH default constant.
REQ-028 The block SHALL be a single module; no sub-module is needed. Next-state and output logic SHALL be in one registered process.

Verification
REQ-029 Reset test: hold reset for 2 edges, then release -> q=0, busy=0, tc=0; reset asserted at q=5 mid-count -> q=0, IDLE next edge, no tc.
REQ-030 One-shot test: start with load_val=4 at edge 0 -> q=4,3,2,1,0 on edges 0..4; tc=1 only after edge 4; busy falls after edge 4.
REQ-031 Stop test: load_val=9, stop at q=6 -> q stays 6, busy=0, no tc; a later start with 3 -> tc after 3 edges.
REQ-032 Boundary test: start with load_val=0 -> tc one cycle, busy stays 0. With WIDTH=4, load_val=15 -> 15 decrements, tc once. Stop coinciding with q==1 -> no tc.
REQ-033 Auto-reload test (macro defined): auto_reload=1, load_val=3 -> tc at edges 3,6,9, q cycles 3,2,1,3...; stop ends it. A start during COUNT is ignored.
